bpred_bht: RTL and testbench

- Parametrised dynamic branch predictor for the next-generation five-stage pipeline. It replaces the fixed "predict not-taken, flush on taken" policy.
- Fetch (IF) gets a same-cycle combinational prediction and next PC.
- Decode (ID) reports the resolved branch outcome each cycle. The block then updates a direct-mapped table of tagged entries, each holding a saturating counter and a branch target.
- The block also flags mispredicts so that ID can flush IF.

---
 rtl/bpred_bht_if.sv | 58 +++++
 rtl/bpred_bht.sv | 180 ++++++++++++++++++
 tb/tb_bpred_bht.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpred_bht_if.sv
// Branch-history-table interface: groups the IF lookup, ID update/mispredict
// and flush signals shared between the pipeline and the bpred_bht predictor.
// Optional macro BPRED_STATS_EN adds the three 32-bit statistics outputs.
interface bpred_bht_if #(
   parameter int PC_W = 32
);
   // IF-stage lookup
   logic [PC_W-1:0] lu_pc;
   logic            lu_hit;
   logic            lu_taken;
   logic [PC_W-1:0] lu_target;
   logic [PC_W-1:0] lu_next_pc;
   // ID-stage resolution / update
   logic            up_valid;
   logic [PC_W-1:0] up_pc;
   logic            up_taken;
   logic [PC_W-1:0] up_target;
   logic            up_pred_taken;
   logic [PC_W-1:0] up_pred_target;
   logic            up_mispred;
   // whole-table invalidate
   logic            flush_all;
`ifdef BPRED_STATS_EN
   logic [31:0]     stat_updates;
   logic [31:0]     stat_mispred;
   logic [31:0]     stat_alloc;

   // pipeline side
   modport master (
      output lu_pc, up_valid, up_pc, up_taken, up_target,
             up_pred_taken, up_pred_target, flush_all,
      input  lu_hit, lu_taken, lu_target, lu_next_pc, up_mispred,
             stat_updates, stat_mispred, stat_alloc
   );

   // predictor side
   modport slave (
      input  lu_pc, up_valid, up_pc, up_taken, up_target,
             up_pred_taken, up_pred_target, flush_all,
      output lu_hit, lu_taken, lu_target, lu_next_pc, up_mispred,
             stat_updates, stat_mispred, stat_alloc
   );
`else
   // pipeline side
   modport master (
      output lu_pc, up_valid, up_pc, up_taken, up_target,
             up_pred_taken, up_pred_target, flush_all,
      input  lu_hit, lu_taken, lu_target, lu_next_pc, up_mispred
   );

   // predictor side
   modport slave (
      input  lu_pc, up_valid, up_pc, up_taken, up_target,
             up_pred_taken, up_pred_target, flush_all,
      output lu_hit, lu_taken, lu_target, lu_next_pc, up_mispred
   );
`endif
endinterface

// File: rtl/bpred_bht.sv
// bpred_bht: direct-mapped, tagged dynamic branch predictor.
// IF gets a zero-latency prediction and next PC; ID reports each resolved
// branch once, which trains a saturating counter and stored target per entry.
// Taken misses allocate, not-taken misses never allocate. flush_all
// invalidates the table and wins over a same-edge update.
// Optional macro BPRED_STATS_EN adds update/mispredict/allocation counters.
module bpred_bht #(
   parameter int NENTRY = 64,
   parameter int CNT_W  = 2,
   parameter int TAG_W  = 8,
   parameter int PC_W   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   bpred_bht_if.slave bus
);

   localparam int IDX_W    = $clog2(NENTRY);
   localparam int TAG_LSB  = IDX_W + 2;
   localparam int TAG_MSB  = IDX_W + TAG_W + 1;

   // counter encodings: weakly-taken is the MSB alone, weakly-not-taken one below
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);

   // table storage
   logic [NENTRY-1:0] r_valid;
   logic [CNT_W-1:0]  r_cnt [NENTRY];
   logic [TAG_W-1:0]  r_tag [NENTRY];
   logic [PC_W-1:0]   r_tgt [NENTRY];

   // lookup path
   logic [IDX_W-1:0]  w_lu_idx;
   logic [TAG_W-1:0]  w_lu_tag;
   logic              w_lu_hit;
   logic              w_lu_taken;
   logic [PC_W-1:0]   w_lu_target;
   logic [PC_W-1:0]   w_lu_seq_pc;
   logic [PC_W-1:0]   w_lu_next_pc;

   // update path
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_up_hit;
   logic              w_upd_en;
   logic              w_cnt_we;
   logic              w_alloc;
   logic              w_tgt_we;
   logic [CNT_W-1:0]  w_cnt_cur;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_mispred;

   assign w_lu_idx = bus.lu_pc[IDX_W+1:2];
   assign w_lu_tag = bus.lu_pc[TAG_MSB:TAG_LSB];
   assign w_up_idx = bus.up_pc[IDX_W+1:2];
   assign w_up_tag = bus.up_pc[TAG_MSB:TAG_LSB];

   // PC bits outside index/tag (byte offset and high bits) do not select an entry
   logic w_unused_up_pc;
   if (PC_W > TAG_MSB + 1) begin : g_pc_hi
      assign w_unused_up_pc = ^{bus.up_pc[PC_W-1:TAG_MSB+1], bus.up_pc[1:0]};
   end else begin : g_pc_nohi
      assign w_unused_up_pc = ^bus.up_pc[1:0];
   end

   // combinational lookup: reads pre-update state, no bypass from the update port
   always_comb begin
      w_lu_hit     = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
      w_lu_taken   = w_lu_hit && r_cnt[w_lu_idx][CNT_W-1];
      w_lu_seq_pc  = bus.lu_pc + PC_STEP;
      if (w_lu_hit) begin
         w_lu_target = r_tgt[w_lu_idx];
      end else begin
         w_lu_target = {PC_W{1'b0}};
      end
      if (w_lu_taken) begin
         w_lu_next_pc = w_lu_target;
      end else begin
         w_lu_next_pc = w_lu_seq_pc;
      end
   end

   // mispredict flag and update decode; nothing trains while in reset or flushing
   always_comb begin
      w_mispred = rst_n && bus.up_valid &&
                  ((bus.up_taken != bus.up_pred_taken) ||
                   (bus.up_taken && bus.up_pred_taken &&
                    (bus.up_target != bus.up_pred_target)));
      w_upd_en  = rst_n && bus.up_valid && !bus.flush_all;
      w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
      w_cnt_we  = w_upd_en && w_up_hit;
      w_alloc   = w_upd_en && !w_up_hit && bus.up_taken;
      // a taken branch refreshes the target whether it hit or allocated
      w_tgt_we  = w_upd_en && bus.up_taken;
      w_cnt_cur = r_cnt[w_up_idx];
   end

   // saturating counter step toward the resolved outcome
   always_comb begin
      w_cnt_next = w_cnt_cur;
      if (bus.up_taken) begin
         if (w_cnt_cur == CNT_MAX) begin
            w_cnt_next = w_cnt_cur;
         end else begin
            w_cnt_next = w_cnt_cur + CNT_ONE;
         end
      end else begin
         if (w_cnt_cur == CNT_MIN) begin
            w_cnt_next = w_cnt_cur;
         end else begin
            w_cnt_next = w_cnt_cur - CNT_ONE;
         end
      end
   end

   // valid bits and counters: async reset, flush clears valid only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= {NENTRY{1'b0}};
         for (int i = 0; i < NENTRY; i++) begin
            r_cnt[i] <= CNT_WNT;
         end
      end else if (bus.flush_all) begin
         r_valid <= {NENTRY{1'b0}};
      end else if (w_alloc) begin
         r_valid[w_up_idx] <= 1'b1;
         r_cnt[w_up_idx]   <= CNT_WT;
      end else if (w_cnt_we) begin
         r_cnt[w_up_idx]   <= w_cnt_next;
      end else begin
         r_valid <= r_valid;
      end
   end

   // tags and targets carry no reset: they are ignored until valid is set
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_tag[w_up_idx] <= w_up_tag;
      end
      if (w_tgt_we) begin
         r_tgt[w_up_idx] <= bus.up_target;
      end
   end

   assign bus.lu_hit     = w_lu_hit;
   assign bus.lu_taken   = w_lu_taken;
   assign bus.lu_target  = w_lu_target;
   assign bus.lu_next_pc = w_lu_next_pc;
   assign bus.up_mispred = w_mispred;

`ifdef BPRED_STATS_EN
   logic [31:0] r_stat_updates;
   logic [31:0] r_stat_mispred;
   logic [31:0] r_stat_alloc;

   // statistics: wrapping counts, frozen during flush, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_updates <= 32'd0;
         r_stat_mispred <= 32'd0;
         r_stat_alloc   <= 32'd0;
      end else if (!bus.flush_all) begin
         r_stat_updates <= r_stat_updates + {31'd0, bus.up_valid};
         r_stat_mispred <= r_stat_mispred + {31'd0, w_mispred};
         r_stat_alloc   <= r_stat_alloc + {31'd0, w_alloc};
      end else begin
         r_stat_updates <= r_stat_updates;
      end
   end

   assign bus.stat_updates = r_stat_updates;
   assign bus.stat_mispred = r_stat_mispred;
   assign bus.stat_alloc   = r_stat_alloc;
`endif

endmodule

// File: tb/tb_bpred_bht.sv
// Self-checking bench for bpred_bht: scenario tasks push expected lookup and
// mispredict results into a scoreboard queue when stimulus is driven and pop
// them for comparison once the combinational outputs settle.
module tb_bpred_bht;

   localparam int NENTRY = 64;
   localparam int CNT_W  = 2;
   localparam int TAG_W  = 8;
   localparam int PC_W   = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bpred_bht_if #(.PC_W(PC_W)) bus ();

   bpred_bht #(
      .NENTRY(NENTRY), .CNT_W(CNT_W), .TAG_W(TAG_W), .PC_W(PC_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      string       name;
      logic [66:0] v;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] lpc;
      logic        v;
      logic [31:0] upc;
      logic        tk;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic        fl;
      logic [66:0] exp;
   } step_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // observed vector: {hit, taken, target, next_pc, mispred}
   wire [66:0] obs = {bus.lu_hit, bus.lu_taken, bus.lu_target, bus.lu_next_pc, bus.up_mispred};

   function automatic logic [66:0] mk(input logic hit, input logic tk, input logic [31:0] tgt,
                                      input logic [31:0] nxt, input logic mis);
      return {hit, tk, tgt, nxt, mis};
   endfunction

   function automatic step_t st(input string name, input logic [31:0] lpc, input logic v,
                                input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                                input logic ptk, input logic [31:0] ptgt, input logic fl,
                                input logic [66:0] exp);
      step_t s;
      s.name = name; s.lpc = lpc; s.v = v; s.upc = upc; s.tk = tk; s.tgt = tgt;
      s.ptk = ptk; s.ptgt = ptgt; s.fl = fl; s.exp = exp;
      return s;
   endfunction

   task automatic drive(input step_t s);
      bus.lu_pc          = s.lpc;
      bus.up_valid       = s.v;
      bus.up_pc          = s.upc;
      bus.up_taken       = s.tk;
      bus.up_target      = s.tgt;
      bus.up_pred_taken  = s.ptk;
      bus.up_pred_target = s.ptgt;
      bus.flush_all      = s.fl;
   endtask

   task automatic test_reset();
      step_t t[$];
      exp_t  ex;
      // an update presented during reset must be ignored
      t.push_back(st("reset_lookup",   32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)));
      t.push_back(st("reset_pc_wrap",  32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
`ifdef BPRED_STATS_EN
      n_checks++;
      if ({bus.stat_updates, bus.stat_mispred, bus.stat_alloc} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_stats: got %h expected 0", {bus.stat_updates, bus.stat_mispred, bus.stat_alloc});
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(st("reset_released", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
               mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)));
      sb.push_back('{"reset_released", mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
   endtask

   task automatic test_alloc();
      step_t t[$];
      exp_t  ex;
      t.push_back(st("alloc_same_cycle", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b1)));
      t.push_back(st("alloc_visible",    32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b1, 32'h100, 32'h100, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
   endtask

   // counter 2 -> 3 -> 3 -> 2 -> 1 -> 0; each row shows the pre-edge state
   task automatic test_counter();
      step_t t[$];
      exp_t  ex;
      t.push_back(st("cnt_t1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0,
                     mk(1'b1, 1'b1, 32'h100, 32'h100, 1'b0)));
      t.push_back(st("cnt_t2_tgt_miss", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0,
                     mk(1'b1, 1'b1, 32'h100, 32'h100, 1'b1)));
      t.push_back(st("cnt_n1", 32'h40, 1'b1, 32'h40, 1'b0, 32'h200, 1'b1, 32'h100, 1'b0,
                     mk(1'b1, 1'b1, 32'h100, 32'h100, 1'b1)));
      t.push_back(st("cnt_n2", 32'h40, 1'b1, 32'h40, 1'b0, 32'h200, 1'b0, 32'h200, 1'b0,
                     mk(1'b1, 1'b1, 32'h100, 32'h100, 1'b0)));
      t.push_back(st("cnt_n3", 32'h40, 1'b1, 32'h40, 1'b0, 32'h200, 1'b0, 32'h200, 1'b0,
                     mk(1'b1, 1'b0, 32'h100, 32'h44, 1'b0)));
      t.push_back(st("cnt_final", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b0, 32'h100, 32'h44, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
   endtask

   // 0x140 shares the index of 0x40 with a different tag
   task automatic test_alias();
      step_t t[$];
      exp_t  ex;
      t.push_back(st("alias_nt_update", 32'h40, 1'b1, 32'h140, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b0, 32'h100, 32'h44, 1'b0)));
      t.push_back(st("alias_nt_no_change", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b0, 32'h100, 32'h44, 1'b0)));
      t.push_back(st("alias_t_update", 32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h144, 1'b0)));
      t.push_back(st("alias_evicted", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)));
      t.push_back(st("alias_new_owner", 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b1, 32'h300, 32'h300, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
   endtask

   // both saturation limits on entry 0x80, plus byte-offset bits ignored
   task automatic test_saturate();
      step_t t[$];
      exp_t  ex;
      t.push_back(st("sat_alloc", 32'h80, 1'b1, 32'h80, 1'b1, 32'h800, 1'b1, 32'h800, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h84, 1'b0)));
      t.push_back(st("sat_t_from2", 32'h80, 1'b1, 32'h80, 1'b1, 32'h800, 1'b1, 32'h800, 1'b0,
                     mk(1'b1, 1'b1, 32'h800, 32'h800, 1'b0)));
      t.push_back(st("sat_t_from3", 32'h80, 1'b1, 32'h80, 1'b1, 32'h800, 1'b1, 32'h800, 1'b0,
                     mk(1'b1, 1'b1, 32'h800, 32'h800, 1'b0)));
      t.push_back(st("sat_high_hold", 32'h80, 1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 32'h900, 1'b0,
                     mk(1'b1, 1'b1, 32'h800, 32'h800, 1'b0)));
      t.push_back(st("sat_n_from2", 32'h80, 1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 32'h900, 1'b0,
                     mk(1'b1, 1'b1, 32'h800, 32'h800, 1'b0)));
      t.push_back(st("sat_n_from1", 32'h80, 1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 32'h900, 1'b0,
                     mk(1'b1, 1'b0, 32'h800, 32'h84, 1'b0)));
      t.push_back(st("sat_n_from0", 32'h80, 1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 32'h900, 1'b0,
                     mk(1'b1, 1'b0, 32'h800, 32'h84, 1'b0)));
      t.push_back(st("sat_low_hold", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b0, 32'h800, 32'h84, 1'b0)));
      t.push_back(st("sat_byte_offset", 32'h83, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b1, 1'b0, 32'h800, 32'h87, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
   endtask

   // lookup sees old state alongside flush; update is dropped; table empties
   task automatic test_flush();
      step_t t[$];
      exp_t  ex;
      t.push_back(st("flush_same_cycle", 32'h140, 1'b1, 32'h140, 1'b1, 32'h500, 1'b1, 32'h300, 1'b1,
                     mk(1'b1, 1'b1, 32'h300, 32'h300, 1'b1)));
      t.push_back(st("flush_drop_update", 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h144, 1'b0)));
      t.push_back(st("flush_clear_80", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h84, 1'b0)));
      t.push_back(st("flush_clear_40", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                     mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)));
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         sb.push_back('{t[i].name, t[i].exp});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
      end
   endtask

   // randomised back-to-back updates on a few colliding PCs against a reference table
   task automatic test_back_to_back();
      logic              m_valid [NENTRY];
      logic [TAG_W-1:0]  m_tag   [NENTRY];
      logic [CNT_W-1:0]  m_cnt   [NENTRY];
      logic [31:0]       m_tgt   [NENTRY];
      step_t             s;
      exp_t              ex;
      int                li, ui;
      logic              hit, tkp, uhit, mis;
      logic [31:0]       etgt, enxt;
      for (int k = 0; k < NENTRY; k++) begin
         m_valid[k] = 1'b0;
         m_tag[k]   = '0;
         m_cnt[k]   = 2'd1;
         m_tgt[k]   = 32'h0;
      end
      for (int n = 0; n < 300; n++) begin
         s.name = "b2b";
         s.lpc  = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 1)) << 8) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         s.upc  = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 1)) << 8) |
                  (32'($urandom_range(0, 3)) << 2);
         s.v    = ($urandom_range(0, 3) != 0);
         s.tk   = 1'($urandom_range(0, 1));
         s.tgt  = 32'($urandom_range(1, 8)) << 12;
         s.ptk  = 1'($urandom_range(0, 1));
         s.ptgt = ($urandom_range(0, 1) != 0) ? s.tgt : (32'($urandom_range(1, 8)) << 12);
         s.fl   = ($urandom_range(0, 31) == 0);
         li     = int'(s.lpc[7:2]);
         hit    = m_valid[li] && (m_tag[li] == s.lpc[15:8]);
         tkp    = hit && m_cnt[li][1];
         etgt   = hit ? m_tgt[li] : 32'h0;
         enxt   = tkp ? etgt : s.lpc + 32'd4;
         mis    = s.v && ((s.tk != s.ptk) || (s.tk && s.ptk && (s.tgt != s.ptgt)));
         @(negedge clk);
         drive(s);
         sb.push_back('{$sformatf("b2b_%0d", n), mk(hit, tkp, etgt, enxt, mis)});
         #1;
         ex = sb.pop_front();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
         end
         // reference state for the coming edge
         if (s.fl) begin
            for (int k = 0; k < NENTRY; k++) m_valid[k] = 1'b0;
         end else if (s.v) begin
            ui   = int'(s.upc[7:2]);
            uhit = m_valid[ui] && (m_tag[ui] == s.upc[15:8]);
            if (uhit) begin
               if (s.tk) begin
                  if (m_cnt[ui] != 2'd3) m_cnt[ui] = m_cnt[ui] + 2'd1;
                  m_tgt[ui] = s.tgt;
               end else if (m_cnt[ui] != 2'd0) begin
                  m_cnt[ui] = m_cnt[ui] - 2'd1;
               end
            end else if (s.tk) begin
               m_valid[ui] = 1'b1;
               m_tag[ui]   = s.upc[15:8];
               m_cnt[ui]   = 2'd2;
               m_tgt[ui]   = s.tgt;
            end
         end
      end
      @(negedge clk);
      drive(st("b2b_idle", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 67'd0));
      @(negedge clk);
      bus.flush_all = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_t ex;
      @(negedge clk);
      drive(st("arst_prefill", 32'h40, 1'b1, 32'h40, 1'b1, 32'h700, 1'b1, 32'h700, 1'b0, 67'd0));
      sb.push_back('{"arst_prefill", mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
      @(negedge clk);
      bus.up_valid = 1'b0;
      sb.push_back('{"arst_populated", mk(1'b1, 1'b1, 32'h700, 32'h700, 1'b0)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
      // mid-cycle reset with a mispredicting update pending
      #2;
      bus.up_valid      = 1'b1;
      bus.up_taken      = 1'b0;
      bus.up_pred_taken = 1'b1;
      rst_n             = 1'b0;
      sb.push_back('{"arst_immediate", mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b0)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
`ifdef BPRED_STATS_EN
      n_checks++;
      if ({bus.stat_updates, bus.stat_mispred, bus.stat_alloc} !== 96'd0) begin
         n_fail++;
         $display("FAIL arst_stats: got %h expected 0", {bus.stat_updates, bus.stat_mispred, bus.stat_alloc});
      end
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(st("arst_first_edge", 32'h40, 1'b1, 32'h40, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 67'd0));
      sb.push_back('{"arst_first_edge_pre", mk(1'b0, 1'b0, 32'h0, 32'h44, 1'b1)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
      @(negedge clk);
      bus.up_valid = 1'b0;
      sb.push_back('{"arst_first_edge_post", mk(1'b1, 1'b1, 32'h900, 32'h900, 1'b0)});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (obs !== ex.v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", ex.name, obs, ex.v);
      end
   endtask

   initial begin
      drive(st("init", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 67'd0));
      test_reset();
      test_alloc();
      test_counter();
      test_alias();
      test_saturate();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
